add_reduce_seq: RTL and testbench

- Multi-cycle reduction adder: captures NUM_IN operands on a start strobe and sums them with NUM_ADD shared adder units over a fixed number of steps.
- Returns the sum with a one-cycle done strobe.
- Parametrised successor of the fixed 7-input, 2-adder sequential summer. Adds width/depth/adder-count generalisation, an unsigned saturating mode, an overflow flag, a busy output and restart-while-busy.
- Sits as a leaf datapath kernel under the generated top-level controllers.

---
 rtl/add_reduce_seq.sv | 212 +++++++++++++++++++++
 tb/tb_add_reduce_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_reduce_seq.sv
`default_nettype none
// ============================================================================
//  Module   : add_reduce_seq
//  Purpose  : Multi-cycle reduction adder. Captures NUM_IN operands on a start
//             strobe, then sums them with NUM_ADD shared adders over a fixed
//             number of steps. Optional unsigned saturation and an overflow
//             flag that reflects the true (unbounded) sum.
//  Ports    : clk       - clock, rising edge
//             rst_n     - asynchronous active-low reset
//             r_enable  - start strobe (capture operands, restart if busy)
//             sat_mode  - 0 wrap, 1 unsigned saturate (captured with operands)
//             init      - packed operands, operand i = init[i*WIDTH +: WIDTH]
//             busy      - high from capture until the done edge
//             w_enable  - one-cycle done strobe
//             result    - sum, held between done strobes
//             overflow  - true sum >= 2^WIDTH, valid with result
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module add_reduce_seq #(
  parameter int WIDTH   = 64,
  parameter int NUM_IN  = 7,
  parameter int NUM_ADD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    r_enable,
  input  logic                    sat_mode,
  input  logic [NUM_IN*WIDTH-1:0] init,
  output logic                    busy,
  output logic                    w_enable,
  output logic [WIDTH-1:0]        result,
  output logic                    overflow
);

  // Live-count width: must hold the value NUM_IN itself.
  localparam int CNT_W = $clog2(NUM_IN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   slot_q [NUM_IN];
  logic [WIDTH-1:0]   slot_d [NUM_IN];
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               sat_q,      sat_d;
  logic               acc_ovf_q,  acc_ovf_d;
  logic               busy_q,     busy_d;
  logic               w_enable_q, w_enable_d;
  logic [WIDTH-1:0]   result_q,   result_d;
  logic               overflow_q, overflow_d;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  // slot_pad extends the slot file with zeros so that every shifted read
  // (k + pairs) and every adder operand index stays in range for all
  // parameter combinations without per-index guards.
  logic [WIDTH-1:0]   slot_pad  [2*NUM_IN];
  logic [WIDTH-1:0]   add_val   [NUM_IN];
  logic               add_carry [NUM_IN];
  logic [WIDTH-1:0]   slot_step [NUM_IN];
  logic [CNT_W-1:0]   pairs;
  logic               ovf_step;

  for (genvar k = 0; k < 2*NUM_IN; k++) begin : g_pad
    if (k < NUM_IN) begin : g_live
      assign slot_pad[k] = slot_q[k];
    end else begin : g_zero
      assign slot_pad[k] = '0;
    end
  end

  // Physical adders: adder j always sums slots 2j and 2j+1. Whether its
  // output is used in a given step depends on the number of pairs.
  for (genvar j = 0; j < NUM_IN; j++) begin : g_adder
    if (j < NUM_ADD) begin : g_unit
      logic [WIDTH:0] sum_w;
      assign sum_w        = {1'b0, slot_pad[2*j]} + {1'b0, slot_pad[2*j+1]};
      assign add_carry[j] = sum_w[WIDTH];
      assign add_val[j]   = (sum_w[WIDTH] && sat_q) ? {WIDTH{1'b1}}
                                                    : sum_w[WIDTH-1:0];
    end else begin : g_none
      assign add_carry[j] = 1'b0;
      assign add_val[j]   = '0;
    end
  end

  // One reduction step: p = min(NUM_ADD, n/2) pairwise sums land in slots
  // 0..p-1, the unpaired tail 2p..n-1 slides down to p..n-p-1. A slot k >= p
  // therefore reads slot k+p; the pair count is decoded against each legal
  // value so every read index is a constant.
  always_comb begin
    pairs = cnt_q >> 1;
    if (pairs > CNT_W'(NUM_ADD)) begin
      pairs = CNT_W'(NUM_ADD);
    end

    ovf_step = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (CNT_W'(j) < pairs) begin
        ovf_step = ovf_step | add_carry[j];
      end
    end

    for (int k = 0; k < NUM_IN; k++) begin
      slot_step[k] = slot_q[k];
      for (int p = 0; p <= NUM_ADD; p++) begin
        if (pairs == CNT_W'(p)) begin
          if (k < p) begin
            slot_step[k] = add_val[k];
          end else begin
            slot_step[k] = slot_pad[k+p];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    acc_ovf_d  = acc_ovf_q;
    busy_d     = busy_q;
    w_enable_d = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;

    if (r_enable) begin
      // Capture wins in every state; any in-flight job is dropped silently.
      for (int i = 0; i < NUM_IN; i++) begin
        slot_d[i] = init[i*WIDTH +: WIDTH];
      end
      cnt_d     = CNT_W'(NUM_IN);
      sat_d     = sat_mode;
      acc_ovf_d = 1'b0;
      busy_d    = 1'b1;
      state_d   = RUN;
    end else begin
      case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (cnt_q > CNT_W'(1)) begin
            slot_d    = slot_step;
            cnt_d     = cnt_q - pairs;
            acc_ovf_d = acc_ovf_q | ovf_step;
          end else begin
            result_d   = slot_q[0];
            overflow_d = acc_ovf_q;
            w_enable_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < NUM_IN; i++) begin
        slot_q[i] <= '0;
      end
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      acc_ovf_q  <= 1'b0;
      busy_q     <= 1'b0;
      w_enable_q <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      acc_ovf_q  <= acc_ovf_d;
      busy_q     <= busy_d;
      w_enable_q <= w_enable_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign w_enable = w_enable_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_add_reduce_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_reduce_seq
//  Purpose  : Directed self-checking bench for add_reduce_seq. Five instances
//             cover the default build, an 8-bit build, 8-operand builds with
//             4 and 1 adders, and the single-operand build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_reduce_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (64-bit, 7 operands, 2 adders)
  logic          a_ren = 0, a_sat = 0, a_busy, a_wen, a_ovf;
  logic [447:0]  a_init = '0;
  logic [63:0]   a_res;
  // Instance B: 8-bit, 7 operands, 2 adders
  logic          b_ren = 0, b_sat = 0, b_busy, b_wen, b_ovf;
  logic [55:0]   b_init = '0;
  logic [7:0]    b_res;
  // Instance C: 16-bit, 8 operands, 4 adders
  logic          c_ren = 0, c_busy, c_wen, c_ovf;
  logic [127:0]  c_init = '0;
  logic [15:0]   c_res;
  // Instance D: 16-bit, 8 operands, 1 adder
  logic          d_ren = 0, d_busy, d_wen, d_ovf;
  logic [127:0]  d_init = '0;
  logic [15:0]   d_res;
  // Instance E: 16-bit, 1 operand
  logic          e_ren = 0, e_busy, e_wen, e_ovf;
  logic [15:0]   e_init = '0;
  logic [15:0]   e_res;

  add_reduce_seq u_a (
    .clk(clk), .rst_n(rst_n), .r_enable(a_ren), .sat_mode(a_sat), .init(a_init),
    .busy(a_busy), .w_enable(a_wen), .result(a_res), .overflow(a_ovf));

  add_reduce_seq #(.WIDTH(8), .NUM_IN(7), .NUM_ADD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .r_enable(b_ren), .sat_mode(b_sat), .init(b_init),
    .busy(b_busy), .w_enable(b_wen), .result(b_res), .overflow(b_ovf));

  add_reduce_seq #(.WIDTH(16), .NUM_IN(8), .NUM_ADD(4)) u_c (
    .clk(clk), .rst_n(rst_n), .r_enable(c_ren), .sat_mode(1'b0), .init(c_init),
    .busy(c_busy), .w_enable(c_wen), .result(c_res), .overflow(c_ovf));

  add_reduce_seq #(.WIDTH(16), .NUM_IN(8), .NUM_ADD(1)) u_d (
    .clk(clk), .rst_n(rst_n), .r_enable(d_ren), .sat_mode(1'b0), .init(d_init),
    .busy(d_busy), .w_enable(d_wen), .result(d_res), .overflow(d_ovf));

  add_reduce_seq #(.WIDTH(16), .NUM_IN(1), .NUM_ADD(1)) u_e (
    .clk(clk), .rst_n(rst_n), .r_enable(e_ren), .sat_mode(1'b0), .init(e_init),
    .busy(e_busy), .w_enable(e_wen), .result(e_res), .overflow(e_ovf));

  // Done-pulse counter for instance A, sampled mid-cycle.
  int a_pulses = 0;
  always @(negedge clk) if (a_wen === 1'b1) a_pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_a_seq();
    for (int i = 0; i < 7; i++) a_init[i*64 +: 64] = 64'(i + 1);
  endtask

  int p0;

  initial begin
    // ---------------- reset state ----------------
    ticks(2);
    chk("rst_busy", a_busy, 0);
    chk("rst_wen",  a_wen,  0);
    chk("rst_res",  a_res,  0);
    chk("rst_ovf",  a_ovf,  0);
    rst_n = 1'b1;
    tick();

    // ---------------- A: 1..7 -> 28, done after E5 ----------------
    load_a_seq();
    a_ren = 1;
    tick();                                   // E0
    a_ren = 0;
    a_init = '1;                              // must not affect running job
    a_sat  = 1;
    chk("a_busy_e0", a_busy, 1);
    chk("a_wen_e0",  a_wen,  0);
    ticks(4);                                 // E4
    chk("a_busy_e4", a_busy, 1);
    chk("a_wen_e4",  a_wen,  0);
    tick();                                   // E5
    chk("a_wen_e5",  a_wen,  1);
    chk("a_busy_e5", a_busy, 0);
    chk("a_res_28",  a_res,  28);
    chk("a_ovf_28",  a_ovf,  0);
    tick();                                   // E6
    chk("a_wen_e6",  a_wen,  0);
    chk("a_res_hold", a_res, 28);
    a_sat = 0;

    // ---------------- B: 7 x 0x40 wrap then saturate ----------------
    b_init = {7{8'h40}};
    b_sat  = 0;
    b_ren  = 1;
    tick();
    b_ren  = 0;
    ticks(5);
    chk("b_wen_wrap", b_wen, 1);
    chk("b_res_wrap", b_res, 8'hC0);
    chk("b_ovf_wrap", b_ovf, 1);
    b_sat = 1;
    b_ren = 1;                                // capture on the DONE edge
    tick();
    b_ren = 0;
    chk("b_busy_restart", b_busy, 1);
    chk("b_res_held",     b_res,  8'hC0);
    ticks(5);
    chk("b_wen_sat", b_wen, 1);
    chk("b_res_sat", b_res, 8'hFF);
    chk("b_ovf_sat", b_ovf, 1);

    // ---------------- C/D: 10..80 with 4 and 1 adders ----------------
    for (int i = 0; i < 8; i++) begin
      c_init[i*16 +: 16] = 16'((i + 1) * 10);
      d_init[i*16 +: 16] = 16'((i + 1) * 10);
    end
    c_ren = 1; d_ren = 1;
    tick();                                   // E0
    c_ren = 0; d_ren = 0;
    ticks(3);                                 // E3
    chk("c_wen_e3", c_wen, 0);
    tick();                                   // E4
    chk("c_wen_e4", c_wen, 1);
    chk("c_res",    c_res, 360);
    chk("c_ovf",    c_ovf, 0);
    chk("d_wen_e4", d_wen, 0);
    ticks(3);                                 // E7
    chk("d_wen_e7", d_wen, 0);
    tick();                                   // E8
    chk("d_wen_e8", d_wen, 1);
    chk("d_res",    d_res, 360);

    // ---------------- A: restart at E2 with 7 x 100 ----------------
    load_a_seq();
    a_ren = 1;
    tick();                                   // E0
    a_ren = 0;
    tick();                                   // E1
    for (int i = 0; i < 7; i++) a_init[i*64 +: 64] = 64'd100;
    a_ren = 1;
    p0 = a_pulses;
    tick();                                   // E2 (restart)
    a_ren = 0;
    ticks(4);                                 // E6
    chk("rs_wen_e6", a_wen, 0);
    tick();                                   // E7
    chk("rs_wen_e7", a_wen, 1);
    chk("rs_res",    a_res, 700);
    ticks(3);
    chk("rs_pulses", 64'(a_pulses - p0), 1);

    // ---------------- A: r_enable held high ----------------
    load_a_seq();
    p0 = a_pulses;
    a_ren = 1;
    ticks(6);
    a_ren = 0;
    chk("hold_pulses", 64'(a_pulses - p0), 0);
    chk("hold_busy",   a_busy, 1);
    ticks(5);
    chk("hold_wen", a_wen, 1);
    chk("hold_res", a_res, 28);

    // ---------------- reset mid-run at E3 ----------------
    a_ren = 1;
    tick();                                   // E0
    a_ren = 0;
    ticks(3);                                 // E3
    #2;
    rst_n = 0;
    #1;
    chk("mr_busy",  a_busy, 0);
    chk("mr_wen",   a_wen,  0);
    chk("mr_res",   a_res,  0);
    chk("mr_ovf",   a_ovf,  0);
    chk("mr_b_res", b_res,  0);
    chk("mr_b_ovf", b_ovf,  0);
    tick();
    rst_n = 1;
    p0 = a_pulses;
    ticks(8);
    chk("mr_no_pulse", 64'(a_pulses - p0), 0);
    chk("mr_idle",     a_busy, 0);

    // ---------------- E: single operand, back-to-back ----------------
    e_init = 16'hDEAD;
    e_ren  = 1;
    tick();                                   // E0
    e_ren  = 0;
    chk("e_busy_e0", e_busy, 1);
    chk("e_wen_e0",  e_wen,  0);
    tick();                                   // E1
    chk("e_wen_e1",  e_wen,  1);
    chk("e_res",     e_res,  16'hDEAD);
    chk("e_ovf",     e_ovf,  0);
    e_init = 16'hBEEF;
    e_ren  = 1;
    tick();                                   // capture on DONE edge
    e_ren  = 0;
    chk("e_wen_b2b",  e_wen,  0);
    chk("e_busy_b2b", e_busy, 1);
    chk("e_res_held", e_res,  16'hDEAD);
    tick();
    chk("e_wen_2",  e_wen, 1);
    chk("e_res_2",  e_res, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
